alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 47 ++++
 rtl/alu_sched.sv | 140 ++++++++++++++
 tb/tb_alu_sched.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// Bundle of the two requester ports plus the drive/return path of the shared ALU.
// The slave modport is the scheduler's view; master is the requester/ALU side.
interface alu_sched_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_aluc;
  logic        req0_ready;
  logic        rsp0_valid;
  logic [31:0] rsp0_res;
  logic        rsp0_zero;
  logic        rsp0_ready;

  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_aluc;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_res;
  logic        rsp1_zero;
  logic        rsp1_ready;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_res;
  logic        alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_aluc, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_aluc, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_res, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_res, rsp1_zero,
    output alu_a, alu_b, alu_aluc,
    input  alu_res, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_aluc, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_aluc, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_res, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_res, rsp1_zero,
    input  alu_a, alu_b, alu_aluc,
    output alu_res, alu_zero
  );
endinterface

// File: rtl/alu_sched.sv
// Two-port scheduler sharing one combinational ALU: IDLE -> EXEC -> RESP per operation.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed port-0 priority; default is round-robin.
module alu_sched (
  input  logic       clk,
  input  logic       rst,
  alu_sched_if.slave bus,
  output logic       busy,
  output logic [7:0] ops_done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] req_a    [2];
  logic [31:0] req_b    [2];
  logic [3:0]  req_aluc [2];

  logic [31:0] rsp_res_reg [2];
  logic [1:0]  rsp_zero_reg;

  logic        grant;
  logic        accept;
  logic        rsp_done;
  logic        owner_reg;
  logic [31:0] alu_a_reg;
  logic [31:0] alu_b_reg;
  logic [3:0]  alu_aluc_reg;
  logic [7:0]  ops_done_reg;

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready   = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a[0]    = bus.req0_a;
  assign req_a[1]    = bus.req1_a;
  assign req_b[0]    = bus.req0_b;
  assign req_b[1]    = bus.req1_b;
  assign req_aluc[0] = bus.req0_aluc;
  assign req_aluc[1] = bus.req1_aluc;

`ifdef ALU_SCHED_FIXED_PRIO_EN
  // Port 0 wins whenever it is valid.
  assign grant = ~req_valid[0];
`else
  logic last_reg;

  always_comb begin
    grant = ~req_valid[0];
    if (req_valid[0] && req_valid[1]) begin
      grant = ~last_reg;
    end
  end
`endif

  assign accept   = (state_reg == IDLE) && !rst && req_valid[grant];
  assign rsp_done = (state_reg == RESP) && rsp_ready[owner_reg];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = accept && (grant == 1'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));

      // Result is captured only for the owner, so the other port's response holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_res_reg[gi]  <= 32'd0;
          rsp_zero_reg[gi] <= 1'b0;
        end else if ((state_reg == EXEC) && (owner_reg == 1'(gi))) begin
          rsp_res_reg[gi]  <= bus.alu_res;
          rsp_zero_reg[gi] <= bus.alu_zero;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_reg    <= 32'd0;
      alu_b_reg    <= 32'd0;
      alu_aluc_reg <= 4'd0;
      owner_reg    <= 1'b0;
      ops_done_reg <= 8'd0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_reg     <= 1'b1;
`endif
    end else begin
      if (accept) begin
        alu_a_reg    <= req_a[grant];
        alu_b_reg    <= req_b[grant];
        alu_aluc_reg <= req_aluc[grant];
        owner_reg    <= grant;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_reg     <= grant;
`endif
      end
      if (rsp_done) begin
        ops_done_reg <= ops_done_reg + 8'd1;
      end
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_res   = rsp_res_reg[0];
  assign bus.rsp1_res   = rsp_res_reg[1];
  assign bus.rsp0_zero  = rsp_zero_reg[0];
  assign bus.rsp1_zero  = rsp_zero_reg[1];
  assign bus.alu_a      = alu_a_reg;
  assign bus.alu_b      = alu_b_reg;
  assign bus.alu_aluc   = alu_aluc_reg;

  assign busy     = (state_reg != IDLE);
  assign ops_done = ops_done_reg;
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched; the shared ALU is a small behavioural model here.
module tb_alu_sched;
  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] ops_done;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_sched_if bus();

  alu_sched dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  // 0000 add, 0001 or, 0100 sub, 1111 arithmetic shift of b right by a, else xor.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] aluc);
    case (aluc)
      4'b0000: return a + b;
      4'b0001: return a | b;
      4'b0100: return a - b;
      4'b1111: return 32'($signed(b) >>> a[4:0]);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_res  = alu_model(bus.alu_a, bus.alu_b, bus.alu_aluc);
  assign bus.alu_zero = (bus.alu_res == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_aluc = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_aluc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete operation with rsp_ready already high on the port.
  task automatic run_op(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] aluc, input logic [31:0] exp_res,
                        input logic exp_zero, input string tag);
    if (port == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_aluc = aluc;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_aluc = aluc;
    end
    #1;
    check({tag, "_ready"}, (port == 0) ? bus.req0_ready : bus.req1_ready, 1);
    tick();
    clear_reqs();
    check({tag, "_busy"}, busy, 1);
    tick();
    check({tag, "_valid"}, (port == 0) ? bus.rsp0_valid : bus.rsp1_valid, 1);
    check({tag, "_res"}, (port == 0) ? bus.rsp0_res : bus.rsp1_res, exp_res);
    check({tag, "_zero"}, (port == 0) ? bus.rsp0_zero : bus.rsp1_zero, exp_zero);
    tick();
    check({tag, "_valid_drop"}, (port == 0) ? bus.rsp0_valid : bus.rsp1_valid, 0);
  endtask

  initial begin
    logic [1:0] tie_order [4];
    int         wait_cnt;

    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    do_reset();

    // Reset values
    check("rst_busy", busy, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp0_res", bus.rsp0_res, 0);
    check("rst_rsp1_res", bus.rsp1_res, 0);
    check("rst_rsp1_zero", bus.rsp1_zero, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_aluc", bus.alu_aluc, 0);
    check("rst_ops_done", ops_done, 0);

    // rsp_ready with no response pending does nothing
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    tick();
    tick();
    check("idle_rsp_ready_ops", ops_done, 0);
    check("idle_rsp_ready_busy", busy, 0);

    // Single op 5+3, with a port-1 request that drops before it can be accepted
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_aluc = 4'b0000;
    #1;
    check("single_ready0", bus.req0_ready, 1);
    check("single_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd9; bus.req1_aluc = 4'b0000;
    #1;
    check("single_exec_busy", busy, 1);
    check("single_exec_ready1", bus.req1_ready, 0);
    check("single_alu_a", bus.alu_a, 32'd5);
    check("single_alu_b", bus.alu_b, 32'd3);
    tick();
    bus.req1_valid = 1'b0;
    check("single_rsp0_valid", bus.rsp0_valid, 1);
    check("single_rsp0_res", bus.rsp0_res, 32'd8);
    check("single_rsp0_zero", bus.rsp0_zero, 0);
    check("single_rsp1_valid", bus.rsp1_valid, 0);
    tick();
    check("single_done_valid", bus.rsp0_valid, 0);
    check("single_ops_done", ops_done, 1);
    tick();
    check("dropped_req_busy", busy, 0);
    check("dropped_req_ops", ops_done, 1);

    // Shift on port 1; port 0's response must be left alone
    run_op(1, 32'd4, 32'h8000_0000, 4'b1111, 32'hF800_0000, 1'b0, "shift");
    check("shift_rsp0_res_kept", bus.rsp0_res, 32'd8);
    check("shift_ops_done", ops_done, 2);

    // Backpressure on port 1 while port 0 waits
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_aluc = 4'b0000;
    #1;
    check("bp_ready1", bus.req1_ready, 1);
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_aluc = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp1_valid", bus.rsp1_valid, 1);
      check("bp_rsp1_res", bus.rsp1_res, 32'd7);
      check("bp_ready0", bus.req0_ready, 0);
      check("bp_ready1_low", bus.req1_ready, 0);
      check("bp_busy", busy, 1);
      tick();
    end
    check("bp_rsp0_res_kept", bus.rsp0_res, 32'd8);
    bus.rsp1_ready = 1'b1;
    tick();
    check("bp_release_valid", bus.rsp1_valid, 0);
    check("bp_release_ops", ops_done, 3);
    check("bp_waiter_ready0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("bp_waiter_res", bus.rsp0_res, 32'd2);
    tick();
    check("bp_waiter_ops", ops_done, 4);

    // Tie: both ports valid continuously from reset
    do_reset();
`ifdef ALU_SCHED_FIXED_PRIO_EN
    tie_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    tie_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd7; bus.req0_aluc = 4'b0100;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h0F; bus.req1_b = 32'hF0; bus.req1_aluc = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("tie%0d_grant", i), {bus.req1_ready, bus.req0_ready}, tie_order[i]);
      tick();
      tick();
      if (tie_order[i] == 2'b01) begin
        check($sformatf("tie%0d_rsp0_valid", i), bus.rsp0_valid, 1);
        check($sformatf("tie%0d_rsp0_res", i), bus.rsp0_res, 32'd0);
        check($sformatf("tie%0d_rsp0_zero", i), bus.rsp0_zero, 1);
      end else begin
        check($sformatf("tie%0d_rsp1_valid", i), bus.rsp1_valid, 1);
        check($sformatf("tie%0d_rsp1_res", i), bus.rsp1_res, 32'hFF);
        check($sformatf("tie%0d_rsp1_zero", i), bus.rsp1_zero, 0);
      end
      tick();
    end
    clear_reqs();
    check("tie_ops_done", ops_done, 4);

    // Reset while in EXEC abandons the operation
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_aluc = 4'b0000;
    tick();
    bus.req0_valid = 1'b0;
    check("midrst_in_exec", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_rsp0_valid", bus.rsp0_valid, 0);
    check("midrst_alu_a", bus.alu_a, 0);
    check("midrst_ops_done", ops_done, 0);
    tick();
    check("midrst_no_rsp", bus.rsp0_valid, 0);
    check("midrst_ops_after", ops_done, 0);

    // 256 back-to-back ops on port 1: counter wraps to 0
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_aluc = 4'b0000;
    for (int n = 1; n <= 256; n++) begin
      wait_cnt = 0;
      while (!bus.rsp1_valid && wait_cnt < 8) begin
        tick();
        wait_cnt++;
      end
      if (!bus.rsp1_valid) begin
        check("wrap_timeout", 0, 1);
        break;
      end
      tick();
      if (n == 255) check("wrap_ops_255", ops_done, 8'd255);
      if (n == 256) check("wrap_ops_0", ops_done, 8'd0);
    end
    clear_reqs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
